// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one data-memory port between the IFU and the LSU.
// Handles one transaction at a time: accept, issue downstream, await response, then pulse the owner.
module mem_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic                clock,
  input  logic                reset,

  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_resp_valid,
  output logic [DATA_W-1:0]   ifu_resp_data,

  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic                lsu_wen,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_resp_valid,
  output logic [DATA_W-1:0]   lsu_resp_data,

  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_wen,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_resp_data
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t              state, state_next;
  logic                owner_lsu;
  logic                last_lsu;
  logic [ADDR_W-1:0]   addr_q;
  logic                wen_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] wmask_q;
  logic [DATA_W-1:0]   ifu_data_q;
  logic [DATA_W-1:0]   lsu_data_q;
  logic                grant_ifu, grant_lsu;
  logic                accept_ifu, accept_lsu;

  // On a tie the requester that did not win last time gets the port.
  assign grant_ifu  = ifu_req_valid && (!lsu_req_valid ||  last_lsu);
  assign grant_lsu  = lsu_req_valid && (!ifu_req_valid || !last_lsu);
  assign accept_ifu = ifu_req_valid && ifu_req_ready;
  assign accept_lsu = lsu_req_valid && lsu_req_ready;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept_ifu || accept_lsu) state_next = REQ;
      REQ:     if (mem_req_ready)            state_next = WAIT;
      WAIT:    if (mem_resp_valid)           state_next = RESP;
      RESP:                                  state_next = IDLE;
      default:                               state_next = IDLE;
    endcase
  end

  always_comb begin
    ifu_req_ready  = 1'b0;
    lsu_req_ready  = 1'b0;
    mem_req_valid  = 1'b0;
    ifu_resp_valid = 1'b0;
    lsu_resp_valid = 1'b0;
    case (state)
      IDLE: begin
        ifu_req_ready = grant_ifu;
        lsu_req_ready = grant_lsu;
      end
      REQ:  mem_req_valid = 1'b1;
      RESP: begin
        ifu_resp_valid = !owner_lsu;
        lsu_resp_valid =  owner_lsu;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      owner_lsu  <= 1'b0;
      last_lsu   <= 1'b1;
      addr_q     <= '0;
      wen_q      <= 1'b0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      ifu_data_q <= '0;
      lsu_data_q <= '0;
    end else begin
      if (state == IDLE && (accept_ifu || accept_lsu)) begin
        owner_lsu <= accept_lsu;
        last_lsu  <= accept_lsu;
        if (accept_lsu) begin
          addr_q  <= lsu_addr;
          wen_q   <= lsu_wen;
          wdata_q <= lsu_wdata;
          wmask_q <= lsu_wmask;
        end else begin
          addr_q  <= ifu_addr;
          wen_q   <= 1'b0;
          wdata_q <= '0;
          wmask_q <= '0;
        end
      end
      // Each requester keeps its own data so the non-owner's output is never disturbed.
      if (state == WAIT && mem_resp_valid) begin
        if (owner_lsu) lsu_data_q <= wen_q ? '0 : mem_resp_data;
        else           ifu_data_q <= mem_resp_data;
      end
    end
  end

  assign mem_wen       = wen_q;
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  assign mem_wmask     = wmask_q;
  assign ifu_resp_data = ifu_data_q;
  assign lsu_resp_data = lsu_data_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: fetch, store, round-robin, backpressure,
// spurious memory strobes and reset in the middle of a transaction.
module tb_mem_arbiter;
  logic        clock = 1'b0;
  logic        reset;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
  logic [63:0] ifu_addr, ifu_resp_data;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid;
  logic [63:0] lsu_addr, lsu_wdata, lsu_resp_data;
  logic [7:0]  lsu_wmask;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
  logic [63:0] mem_addr, mem_wdata, mem_resp_data;
  logic [7:0]  mem_wmask;

  int unsigned total = 0;
  int unsigned bad   = 0;

  mem_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
    .clock(clock), .reset(reset),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_data(ifu_resp_data),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_wen(lsu_wen),
    .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_data(lsu_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One arbitration round with both requesters held valid; exp_lsu names the expected winner.
  task automatic both_round(input logic exp_lsu, input logic [63:0] data);
    ifu_req_valid = 1'b1; lsu_req_valid = 1'b1; #1;
    chk("rr_ifu_ready", ifu_req_ready, !exp_lsu);
    chk("rr_lsu_ready", lsu_req_ready, exp_lsu);
    tick();
    mem_req_ready = 1'b1; #1;
    chk("rr_mem_addr", mem_addr, exp_lsu ? 64'h200 : 64'h100);
    chk("rr_ready_req", {ifu_req_ready, lsu_req_ready}, 0);
    tick();
    mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = data; #1;
    chk("rr_ready_wait", {ifu_req_ready, lsu_req_ready}, 0);
    tick();
    mem_resp_valid = 1'b0; #1;
    chk("rr_resp", {ifu_resp_valid, lsu_resp_valid}, exp_lsu ? 64'h1 : 64'h2);
    chk("rr_data", exp_lsu ? lsu_resp_data : ifu_resp_data, data);
    tick();
  endtask

  initial begin
    reset = 1'b1;
    ifu_req_valid = 1'b0; ifu_addr = '0;
    lsu_req_valid = 1'b0; lsu_wen = 1'b0; lsu_addr = '0; lsu_wdata = '0; lsu_wmask = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
    tick(); tick();
    reset = 1'b0; #1;
    chk("rst_readys", {ifu_req_ready, lsu_req_ready}, 0);
    chk("rst_mem_valid", mem_req_valid, 0);
    chk("rst_resp_valids", {ifu_resp_valid, lsu_resp_valid}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_ifu_data", ifu_resp_data, 0);

    // Single IFU fetch: handshake at C0, response pulse at C3.
    ifu_req_valid = 1'b1; ifu_addr = 64'h8000_0000; #1;
    chk("f_ifu_ready", ifu_req_ready, 1);
    chk("f_lsu_ready", lsu_req_ready, 0);
    tick();
    ifu_req_valid = 1'b0; mem_req_ready = 1'b1; #1;
    chk("f_mem_valid", mem_req_valid, 1);
    chk("f_mem_addr", mem_addr, 64'h8000_0000);
    chk("f_mem_wen", mem_wen, 0);
    chk("f_mem_wmask", mem_wmask, 0);
    chk("f_mem_wdata", mem_wdata, 0);
    tick();
    mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 64'h0000_0413_0000_0297; #1;
    chk("f_mem_valid_wait", mem_req_valid, 0);
    chk("f_no_early_resp", ifu_resp_valid, 0);
    tick();
    mem_resp_valid = 1'b0; mem_resp_data = '0; #1;
    chk("f_resp_valid", ifu_resp_valid, 1);
    chk("f_resp_data", ifu_resp_data, 64'h0000_0413_0000_0297);
    chk("f_lsu_quiet", lsu_resp_valid, 0);
    tick();
    chk("f_pulse_one", ifu_resp_valid, 0);
    chk("f_data_hold", ifu_resp_data, 64'h0000_0413_0000_0297);

    // LSU store; the requester's inputs change after handshake to prove they were latched.
    lsu_req_valid = 1'b1; lsu_wen = 1'b1; lsu_addr = 64'h8000_1004;
    lsu_wdata = 64'hDEAD_BEEF_0000_0000; lsu_wmask = 8'hF0; #1;
    chk("s_lsu_ready", lsu_req_ready, 1);
    tick();
    lsu_req_valid = 1'b0; lsu_wen = 1'b0; lsu_addr = 64'h1; lsu_wdata = 64'h1; lsu_wmask = 8'h01;
    mem_req_ready = 1'b1; #1;
    chk("s_mem_valid", mem_req_valid, 1);
    chk("s_mem_wen", mem_wen, 1);
    chk("s_mem_addr", mem_addr, 64'h8000_1004);
    chk("s_mem_wdata", mem_wdata, 64'hDEAD_BEEF_0000_0000);
    chk("s_mem_wmask", mem_wmask, 8'hF0);
    tick();
    mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 64'h1234_5678; #1;
    tick();
    mem_resp_valid = 1'b0; #1;
    chk("s_resp_valid", lsu_resp_valid, 1);
    chk("s_resp_data", lsu_resp_data, 0);
    chk("s_ifu_quiet", ifu_resp_valid, 0);
    tick();
    lsu_wen = 1'b0;

    // Three contested rounds: last grant is LSU, so IFU, LSU, IFU.
    ifu_addr = 64'h100; lsu_addr = 64'h200;
    both_round(1'b0, 64'hA1);
    both_round(1'b1, 64'hB2);
    both_round(1'b0, 64'hC3);
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;

    // Backpressure: 5 cycles of ready low, then 3 WAIT cycles before the response.
    lsu_req_valid = 1'b1; lsu_addr = 64'h8000_2000; #1;
    chk("b_lsu_ready", lsu_req_ready, 1);
    tick();
    lsu_req_valid = 1'b0; lsu_addr = 64'h0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("b_mem_valid_hold", mem_req_valid, 1);
      chk("b_mem_addr_hold", mem_addr, 64'h8000_2000);
      tick();
    end
    mem_req_ready = 1'b1; #1;
    chk("b_mem_valid_last", mem_req_valid, 1);
    tick();
    mem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("b_no_resp", lsu_resp_valid, 0);
      tick();
    end
    mem_resp_valid = 1'b1; mem_resp_data = 64'hCAFE; #1;
    chk("b_no_resp_yet", lsu_resp_valid, 0);
    tick();
    mem_resp_valid = 1'b0; #1;
    chk("b_resp_at_11", lsu_resp_valid, 1);
    chk("b_resp_data", lsu_resp_data, 64'hCAFE);
    tick();

    // Spurious memory strobes in IDLE and in REQ.
    mem_resp_valid = 1'b1; mem_req_ready = 1'b1; mem_resp_data = 64'hBAD; #1;
    chk("sp_idle_mem_valid", mem_req_valid, 0);
    tick();
    chk("sp_idle_resp", {ifu_resp_valid, lsu_resp_valid}, 0);
    chk("sp_idle_mem_valid2", mem_req_valid, 0);
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    ifu_req_valid = 1'b1; ifu_addr = 64'h300; #1;
    chk("sp_ifu_ready", ifu_req_ready, 1);
    tick();
    ifu_req_valid = 1'b0; mem_resp_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("sp_req_hold", mem_req_valid, 1);
      chk("sp_req_resp", {ifu_resp_valid, lsu_resp_valid}, 0);
      tick();
    end
    mem_resp_valid = 1'b0; mem_req_ready = 1'b1; #1;
    chk("sp_req_still", mem_req_valid, 1);
    tick();
    mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 64'h77; #1;
    tick();
    mem_resp_valid = 1'b0; #1;
    chk("sp_final_resp", ifu_resp_valid, 1);
    chk("sp_final_data", ifu_resp_data, 64'h77);
    tick();

    // Reset while in WAIT; last grant is IFU so only reset can make IFU win the next tie.
    ifu_req_valid = 1'b1; ifu_addr = 64'h400; #1;
    tick();
    ifu_req_valid = 1'b0; mem_req_ready = 1'b1; #1;
    tick();
    mem_req_ready = 1'b0; reset = 1'b1; #1;
    chk("r_in_wait", mem_req_valid, 0);
    tick();
    reset = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 64'h55; #1;
    chk("r_mem_valid", mem_req_valid, 0);
    chk("r_readys", {ifu_req_ready, lsu_req_ready}, 0);
    chk("r_resp_valids", {ifu_resp_valid, lsu_resp_valid}, 0);
    chk("r_ifu_data", ifu_resp_data, 0);
    chk("r_lsu_data", lsu_resp_data, 0);
    chk("r_mem_addr", mem_addr, 0);
    tick();
    mem_resp_valid = 1'b0; #1;
    chk("r_late_dropped", {ifu_resp_valid, lsu_resp_valid}, 0);
    ifu_req_valid = 1'b1; lsu_req_valid = 1'b1; #1;
    chk("r_tie_ifu", ifu_req_ready, 1);
    chk("r_tie_lsu", lsu_req_ready, 0);
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
